// File: rtl/wb_counter_bank.sv
// Wishbone slave holding CHANNELS compare/match counters. Each channel toggles
// one GPIO on every match and can raise the shared user interrupt.
module wb_counter_bank #(
    parameter int          CHANNELS = 4,
    parameter int          WIDTH    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [CHANNELS-1:0] io_out,
    output logic [CHANNELS-1:0] io_oeb,
    output logic [2:0]          irq
);

    localparam logic [7:0] STATUS_OFF = 8'h80;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    logic                           ack_q, ack_d;
    logic [31:0]                    dat_q, dat_d;
    logic [CHANNELS-1:0][3:0]       ctrl_q, ctrl_d;
    logic [CHANNELS-1:0][WIDTH-1:0] value_q, value_d;
    logic [CHANNELS-1:0][WIDTH-1:0] compare_q, compare_d;
    logic [CHANNELS-1:0]            status_q, status_d;
    logic [CHANNELS-1:0]            tgl_q, tgl_d;
    logic                           irq_q, irq_d;

    logic                hit_s, wr_s, is_status_s, reg_ok_s;
    logic [7:0]          off_s;
    logic [1:0]          reg_sel_s;
    logic [31:0]         wmask_s, chan_rd_s, rd_data_s;
    logic [CHANNELS-1:0] ch_sel_s, match_s, outen_s, irqen_s;
    logic                unused_s;

    // The !ack term forces a dead cycle after every acknowledge.
    assign hit_s       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
    assign wr_s        = hit_s & wbs_we_i;
    assign off_s       = wbs_adr_i[7:0];
    assign reg_sel_s   = off_s[3:2];
    assign is_status_s = (off_s == STATUS_OFF);
    assign reg_ok_s    = ~off_s[7] & (off_s[1:0] == 2'b00);
    assign wmask_s     = byte_mask(wbs_sel_i);
    assign unused_s    = ^{wbs_dat_i, wmask_s};

    // Channel decode, read-data mux and bus handshake / interrupt next state
    always_comb begin
        logic [31:0] word_v;
        ch_sel_s  = '0;
        outen_s   = '0;
        irqen_s   = '0;
        chan_rd_s = 32'h0;
        word_v    = 32'h0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch_sel_s[c] = reg_ok_s & (off_s[6:4] == 3'(c));
            outen_s[c]  = ctrl_q[c][3];
            irqen_s[c]  = ctrl_q[c][2];
            case (reg_sel_s)
                2'd0:    word_v = 32'(ctrl_q[c]);
                2'd1:    word_v = 32'(value_q[c]);
                2'd2:    word_v = 32'(compare_q[c]);
                default: word_v = 32'h0;
            endcase
            chan_rd_s = chan_rd_s | (ch_sel_s[c] ? word_v : 32'h0);
        end
        if (is_status_s) begin
            rd_data_s = 32'(status_q);
        end else begin
            rd_data_s = chan_rd_s;
        end
        ack_d = hit_s;
        if (hit_s & ~wbs_we_i) begin
            dat_d = rd_data_s;
        end else begin
            dat_d = 32'h0;
        end
        irq_d = |(status_q & irqen_s);
    end

    // Counter/match update per channel; bus writes override the count, a new match beats W1C
    always_comb begin
        ctrl_d    = ctrl_q;
        value_d   = value_q;
        compare_d = compare_q;
        tgl_d     = tgl_q;
        match_s   = '0;
        if (wr_s & is_status_s) begin
            status_d = status_q & ~(wbs_dat_i[CHANNELS-1:0] & wmask_s[CHANNELS-1:0]);
        end else begin
            status_d = status_q;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            match_s[c] = ctrl_q[c][0] & (value_q[c] == compare_q[c]);
            if (match_s[c]) begin
                value_d[c]   = '0;
                tgl_d[c]     = ~tgl_q[c];
                status_d[c]  = 1'b1;
                ctrl_d[c][0] = ~ctrl_q[c][1];
            end else if (ctrl_q[c][0]) begin
                value_d[c] = value_q[c] + WIDTH'(1);
            end else begin
                value_d[c] = value_q[c];
            end
            if (wr_s & ch_sel_s[c]) begin
                case (reg_sel_s)
                    2'd0: ctrl_d[c] = (ctrl_q[c] & ~wmask_s[3:0]) | (wbs_dat_i[3:0] & wmask_s[3:0]);
                    2'd1: value_d[c] = (value_q[c] & ~wmask_s[WIDTH-1:0])
                                     | (wbs_dat_i[WIDTH-1:0] & wmask_s[WIDTH-1:0]);
                    2'd2: compare_d[c] = (compare_q[c] & ~wmask_s[WIDTH-1:0])
                                       | (wbs_dat_i[WIDTH-1:0] & wmask_s[WIDTH-1:0]);
                    default: ctrl_d[c] = ctrl_d[c];
                endcase
            end else begin
                ctrl_d[c] = ctrl_d[c];
            end
        end
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            ctrl_q    <= '0;
            value_q   <= '0;
            compare_q <= '0;
            status_q  <= '0;
            tgl_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            ctrl_q    <= ctrl_d;
            value_q   <= value_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            tgl_q     <= tgl_d;
            irq_q     <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign io_out    = tgl_q & outen_s;
    assign io_oeb    = ~outen_s;
    assign irq       = {2'b00, irq_q};

endmodule

// File: tb/tb_wb_counter_bank.sv
// Bench for wb_counter_bank: a 4x32 instance plus a 1x8 instance on a shared bus.
module tb_wb_counter_bank;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack32, ack8, ack_s, sel8;
    logic [31:0] dat32, dat8, dat_s;
    logic [3:0]  io_out, io_oeb;
    logic [0:0]  io_out8, io_oeb8;
    logic [2:0]  irq, irq8;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_counter_bank #(.CHANNELS(4), .WIDTH(32), .BASE_ADR(BASE)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack32), .wbs_dat_o(dat32), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    wb_counter_bank #(.CHANNELS(1), .WIDTH(8), .BASE_ADR(BASE)) u_dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack8), .wbs_dat_o(dat8), .io_out(io_out8), .io_oeb(io_oeb8), .irq(irq8)
    );

    assign ack_s = sel8 ? ack8 : ack32;
    assign dat_s = sel8 ? dat8 : dat32;

    typedef struct {
        logic        ack;
        logic        chk;
        logic [31:0] dat;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        ack;
        logic [31:0] rd;
        string       name;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the bus idle; returns two negedges after the ack.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic exp_ack, input logic [31:0] exp_dat,
                           input string nm);
        exp_t e;
        logic got;
        e.ack = exp_ack; e.chk = exp_ack & ~w; e.dat = exp_dat; e.name = nm;
        sb_q.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack_s) got = 1'b1;
        end
        e = sb_q.pop_front();
        check({e.name, " ack"}, 32'(got), 32'(e.ack));
        if (e.chk && got) check({e.name, " data"}, dat_s, e.dat);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input string nm);
        wb_xfer(1'b1, BASE + 32'(off), d, 4'hF, 1'b1, 32'h0, nm);
    endtask

    task automatic wb_rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
        wb_xfer(1'b0, BASE + 32'(off), 32'h0, 4'hF, 1'b1, exp, nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[17];
        logic seen;
        vt[0]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hF, 1'b1, 32'h0,         "rst_value0"};
        vt[1]  = '{1'b0, BASE + 32'h08, 32'h0,         4'hF, 1'b1, 32'h0,         "rst_compare0"};
        vt[2]  = '{1'b0, BASE + 32'h80, 32'h0,         4'hF, 1'b1, 32'h0,         "rst_status"};
        vt[3]  = '{1'b0, BASE + 32'h00, 32'h0,         4'hF, 1'b1, 32'h0,         "rst_ctrl0"};
        vt[4]  = '{1'b1, BASE + 32'h28, 32'hAABBCCDD,  4'h2, 1'b1, 32'h0,         "lane_wr1"};
        vt[5]  = '{1'b0, BASE + 32'h28, 32'h0,         4'hF, 1'b1, 32'h0000CC00,  "lane_rd1"};
        vt[6]  = '{1'b1, BASE + 32'h28, 32'h11223344,  4'h9, 1'b1, 32'h0,         "lane_wr2"};
        vt[7]  = '{1'b0, BASE + 32'h28, 32'h0,         4'hF, 1'b1, 32'h1100CC44,  "lane_rd2"};
        vt[8]  = '{1'b1, BASE + 32'h20, 32'hFFFFFFF8,  4'hF, 1'b1, 32'h0,         "ctrl2_wr"};
        vt[9]  = '{1'b0, BASE + 32'h20, 32'h0,         4'hF, 1'b1, 32'h8,         "ctrl2_rd"};
        vt[10] = '{1'b0, BASE + 32'h2C, 32'h0,         4'hF, 1'b1, 32'h0,         "pad_rd"};
        vt[11] = '{1'b0, BASE + 32'h24, 32'h0,         4'hF, 1'b1, 32'h0,         "value2_rd"};
        vt[12] = '{1'b1, BASE + 32'h40, 32'hDEADBEEF,  4'hF, 1'b1, 32'h0,         "hole_wr"};
        vt[13] = '{1'b0, BASE + 32'h40, 32'h0,         4'hF, 1'b1, 32'h0,         "hole_rd"};
        vt[14] = '{1'b0, BASE + 32'h84, 32'h0,         4'hF, 1'b1, 32'h0,         "hole84_rd"};
        vt[15] = '{1'b1, BASE + 32'h100, 32'h12345678, 4'hF, 1'b0, 32'h0,         "out_of_window"};
        vt[16] = '{1'b0, 32'h2000_0004, 32'h0,         4'hF, 1'b0, 32'h0,         "foreign_base"};

        sel8 = 1'b0; rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack32), 32'h0);
        check("rst_dat", dat32, 32'h0);
        check("rst_oeb", 32'(io_oeb), 32'hF);
        check("rst_io", 32'(io_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++)
            wb_xfer(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, vt[i].ack, vt[i].rd, vt[i].name);
        check("oeb_ch2", 32'(io_oeb), 32'hB);
        check("io_idle", 32'(io_out), 32'h0);

        // Free-running match on channel 0
        wb_wr(8'h08, 32'h3, "cmp0_wr");
        wb_wr(8'h00, 32'hD, "ctrl0_run");
        for (int k = 3; k <= 11; k++) begin
            @(negedge clk);
            check($sformatf("toggle_k%0d", k), 32'(io_out[0]), 32'((k >= 5) ^ (k >= 9)));
            check($sformatf("irq_k%0d", k), 32'(irq), 32'(k >= 6));
        end
        wb_wr(8'h00, 32'hC, "ctrl0_stop");
        check("irq_held", 32'(irq), 32'h1);
        wb_wr(8'h80, 32'h1, "w1c0");
        check("irq_clr", 32'(irq), 32'h0);
        wb_rd(8'h80, 32'h0, "status_clr");

        // One-shot on channel 1, output disabled
        wb_wr(8'h18, 32'h5, "cmp1_wr");
        wb_wr(8'h10, 32'h3, "ctrl1_oneshot");
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen = seen | io_out[1];
        end
        check("io1_quiet", 32'(seen), 32'h0);
        wb_rd(8'h10, 32'h2, "ctrl1_after");
        wb_rd(8'h14, 32'h0, "value1_after");
        wb_rd(8'h80, 32'h2, "status1_after");
        wb_wr(8'h80, 32'hFF, "w1c_all");

        // W1C lands on the same edge as a new match
        wb_wr(8'h04, 32'h0, "value0_zero");
        wb_wr(8'h00, 32'hD, "ctrl0_rerun");
        repeat (2) @(negedge clk);
        wb_wr(8'h80, 32'h1, "w1c_collide");
        wb_rd(8'h80, 32'h1, "set_beats_w1c");

        // VALUE write while counting, then count resumes from it
        wb_wr(8'h04, 32'h10, "value0_bus");
        wb_rd(8'h04, 32'h11, "value_wr_wins");
        wb_rd(8'h04, 32'h13, "value_counts");
        check("pre_rst_oeb", 32'(io_oeb), 32'hA);
        check("pre_rst_irq", 32'(irq), 32'h1);

        // Reset in the middle of a read
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04; sel = 4'hF;
        #1 rst = 1'b1;
        #1;
        check("arst_ack", 32'(ack32), 32'h0);
        check("arst_dat", dat32, 32'h0);
        check("arst_io", 32'(io_out), 32'h0);
        check("arst_oeb", 32'(io_oeb), 32'hF);
        check("arst_irq", 32'(irq), 32'h0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | ack32;
        end
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | ack32;
        end
        check("arst_no_ack", 32'(seen), 32'h0);
        wb_rd(8'h00, 32'h0, "post_rst_ctrl0");
        wb_rd(8'h80, 32'h0, "post_rst_status");
        wb_rd(8'h28, 32'h0, "post_rst_cmp2");

        // 8-bit instance: truncation and wrap 0xFF -> 0x00 before matching COMPARE=0
        sel8 = 1'b1;
        wb_wr(8'h08, 32'h0001_0000, "w8_cmp_wr");
        wb_rd(8'h08, 32'h0, "w8_cmp_trunc");
        wb_wr(8'h04, 32'h1234_56FE, "w8_val_wr");
        wb_rd(8'h04, 32'hFE, "w8_val_trunc");
        wb_wr(8'h00, 32'h3, "w8_ctrl_run");
        repeat (6) @(negedge clk);
        wb_rd(8'h00, 32'h2, "w8_oneshot_en");
        wb_rd(8'h04, 32'h0, "w8_value_end");
        wb_rd(8'h80, 32'h1, "w8_status");
        sel8 = 1'b0;
        wb_rd(8'h80, 32'h0, "w32_no_match");
        wb_rd(8'h00, 32'h3, "w32_still_on");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
